det_sequencer: RTL and testbench

DET_SEQUENCER -- requirements
Module: det_sequencer

---
 rtl/det_sequencer.sv | 170 +++++++++++++++++
 tb/tb_det_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/det_sequencer.sv
// Determinant sequencer: element entry into a 64-entry array, row-major streaming to an
// external engine, and result capture. Optional macro DET_SEQ_AUTOINC_EN selects auto-increment entry.
module det_sequencer #(
  parameter int unsigned ELEM_W = 4,
  parameter int unsigned DET_W  = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Enter,
  input  logic [2:0]        Row,
  input  logic [2:0]        Col,
  input  logic [ELEM_W-1:0] Data,
  input  logic [3:0]        Size,
  output logic              Ld_valid,
  output logic [ELEM_W-1:0] Ld_data,
  output logic              Ld_last,
  input  logic              Ld_ready,
  output logic              Eng_start,
  input  logic              Eng_done,
  input  logic [DET_W-1:0]  Eng_det,
  output logic [DET_W-1:0]  Det,
  output logic [5:0]        Cur_idx,
  output logic [ELEM_W-1:0] Cur_val,
  output logic              q_I,
  output logic              q_Enter,
  output logic              q_Load,
  output logic              q_Comp,
  output logic              q_Done
);

  localparam int unsigned DEPTH = 64;
  localparam int unsigned IDX_W = 6;

  typedef enum logic [2:0] {
    S_I     = 3'd0,
    S_ENTER = 3'd1,
    S_LOAD  = 3'd2,
    S_COMP  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [ELEM_W-1:0] mem [DEPTH];
  logic [2:0]        r_q, c_q;
  logic [DET_W-1:0]  det_q;
  logic              eng_start_q;
  logic [3:0]        neff;
  logic [2:0]        neff_m1;
  logic              at_last;
  logic              xfer;
  logic              wr_en;
  logic [IDX_W-1:0]  entry_idx;

  // Effective matrix order, clamped to 1..8
  always_comb begin
    neff = Size;
    if (Size == 4'd0) begin
      neff = 4'd1;
    end else if (Size > 4'd8) begin
      neff = 4'd8;
    end
  end

  assign neff_m1 = 3'(neff - 4'd1);
  assign at_last = (r_q == neff_m1) && (c_q == neff_m1);
  assign xfer    = (state == S_LOAD) && Ld_ready;
  assign wr_en   = (state == S_ENTER) && Enter;

`ifdef DET_SEQ_AUTOINC_EN
  logic [IDX_W-1:0] ptr_q;
  logic             unused_rowcol;

  assign unused_rowcol = ^{Row, Col};

  // Entry pointer: cleared when a run starts, advances after each write
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ptr_q <= '0;
    end else if ((state == S_I) && Start) begin
      ptr_q <= '0;
    end else if (wr_en) begin
      ptr_q <= ptr_q + IDX_W'(1);
    end
  end

  assign entry_idx = ptr_q;
`else
  assign entry_idx = {Row, Col};
`endif

  assign Cur_idx = (state == S_LOAD) ? {r_q, c_q} : entry_idx;
  assign Cur_val = mem[Cur_idx];
  assign Ld_data = mem[{r_q, c_q}];

  always_comb begin
    state_nxt = state;
    case (state)
      S_I:     if (Start) state_nxt = S_ENTER;
      S_ENTER: if (Start) state_nxt = S_LOAD;
      S_LOAD:  if (xfer && at_last) state_nxt = S_COMP;
      S_COMP:  if (Eng_done) state_nxt = S_DONE;
      S_DONE:  if (Start) state_nxt = S_I;
      default: state_nxt = S_I;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= S_I;
    end else begin
      state <= state_nxt;
    end
  end

  // Stream pointer walks row-major over the Neff x Neff sub-matrix
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_q <= '0;
      c_q <= '0;
    end else if ((state == S_ENTER) && Start) begin
      r_q <= '0;
      c_q <= '0;
    end else if (xfer) begin
      if (at_last) begin
        r_q <= '0;
        c_q <= '0;
      end else if (c_q == neff_m1) begin
        c_q <= '0;
        r_q <= r_q + 3'd1;
      end else begin
        c_q <= c_q + 3'd1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[entry_idx] <= Data;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      det_q       <= '0;
      eng_start_q <= 1'b0;
    end else begin
      eng_start_q <= xfer && at_last;
      if ((state == S_COMP) && Eng_done) begin
        det_q <= Eng_det;
      end
    end
  end

  assign Det       = det_q;
  assign Eng_start = eng_start_q;
  assign Ld_valid  = (state == S_LOAD);
  assign Ld_last   = (state == S_LOAD) && at_last;

  assign q_I     = (state == S_I);
  assign q_Enter = (state == S_ENTER);
  assign q_Load  = (state == S_LOAD);
  assign q_Comp  = (state == S_COMP);
  assign q_Done  = (state == S_DONE);

endmodule

// File: tb/tb_det_sequencer.sv
// Directed bench for det_sequencer: a reference array model feeds an expected-stream
// queue that is drained as elements are accepted.
module tb_det_sequencer;

  localparam int unsigned ELEM_W = 4;
  localparam int unsigned DET_W  = 32;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              Start, Enter;
  logic [2:0]        Row, Col;
  logic [ELEM_W-1:0] Data;
  logic [3:0]        Size;
  logic              Ld_valid, Ld_last, Ld_ready;
  logic [ELEM_W-1:0] Ld_data;
  logic              Eng_start, Eng_done;
  logic [DET_W-1:0]  Eng_det, Det;
  logic [5:0]        Cur_idx;
  logic [ELEM_W-1:0] Cur_val;
  logic              q_I, q_Enter, q_Load, q_Comp, q_Done;

  int checks = 0;
  int errors = 0;

  logic [ELEM_W-1:0] mdl [64];
  logic [ELEM_W-1:0] exp_data_q [$];
  logic              exp_last_q [$];

  det_sequencer #(.ELEM_W(ELEM_W), .DET_W(DET_W)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Enter(Enter), .Row(Row), .Col(Col),
    .Data(Data), .Size(Size), .Ld_valid(Ld_valid), .Ld_data(Ld_data), .Ld_last(Ld_last),
    .Ld_ready(Ld_ready), .Eng_start(Eng_start), .Eng_done(Eng_done), .Eng_det(Eng_det),
    .Det(Det), .Cur_idx(Cur_idx), .Cur_val(Cur_val), .q_I(q_I), .q_Enter(q_Enter),
    .q_Load(q_Load), .q_Comp(q_Comp), .q_Done(q_Done)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic write_el(input logic [2:0] r, input logic [2:0] c, input logic [ELEM_W-1:0] d);
    Row = r; Col = c; Data = d; Enter = 1'b1;
    tick();
    Enter = 1'b0;
    mdl[{r, c}] = d;
  endtask

  function automatic int neff_of(input logic [3:0] s);
    if (s == 4'd0) return 1;
    if (s > 4'd8) return 8;
    return int'(s);
  endfunction

  task automatic push_stream(input logic [3:0] s);
    int n = neff_of(s);
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++) begin
        exp_data_q.push_back(mdl[r*8 + c]);
        exp_last_q.push_back((r == n-1) && (c == n-1));
      end
  endtask

  // Drain the stream with a repeating 4-cycle ready pattern
  task automatic run_load(input int n, input logic [3:0] pat);
    int xfers = 0;
    int cyc = 0;
    logic rdy;
    logic [ELEM_W-1:0] held;
    logic [ELEM_W-1:0] ed;
    logic el;
    while (Ld_valid === 1'b1 && cyc < 500) begin
      rdy = pat[cyc % 4];
      Ld_ready = rdy;
      held = Ld_data;
      if (rdy) begin
        if (exp_data_q.size() == 0) begin
          check("ld_overrun", 64'(xfers), 64'(n*n));
        end else begin
          ed = exp_data_q.pop_front();
          el = exp_last_q.pop_front();
          check("ld_data", 64'(Ld_data), 64'(ed));
          check("ld_last", 64'(Ld_last), 64'(el));
        end
        xfers++;
      end
      tick();
      if (!rdy) check("ld_hold", 64'(Ld_data), 64'(held));
      cyc++;
    end
    Ld_ready = 1'b0;
    check("ld_xfers", 64'(xfers), 64'(n*n));
    check("ld_budget", 64'(cyc < 500), 64'(1));
    check("ld_queue_empty", 64'(exp_data_q.size()), 64'(0));
    exp_data_q.delete();
    exp_last_q.delete();
  endtask

  task automatic finish_run(input logic [DET_W-1:0] d);
    Eng_det = d; Eng_done = 1'b1;
    tick();
    Eng_done = 1'b0;
    check("done_state", 64'(q_Done), 64'(1));
    check("det_capture", 64'(Det), 64'(d));
    pulse_start();
    check("ack_to_i", 64'(q_I), 64'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    Reset = 1'b1; Start = 0; Enter = 0; Row = 0; Col = 0; Data = 0; Size = 0;
    Ld_ready = 0; Eng_done = 0; Eng_det = '0;
    for (int i = 0; i < 64; i++) mdl[i] = '0;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    tick();

    check("rst_q_I", 64'({q_I, q_Enter, q_Load, q_Comp, q_Done}), 64'(5'b10000));
    check("rst_ld_valid", 64'(Ld_valid), 64'(0));
    check("rst_ld_last", 64'(Ld_last), 64'(0));
    check("rst_eng_start", 64'(Eng_start), 64'(0));
    check("rst_det", 64'(Det), 64'(0));
    check("rst_cur_val", 64'(Cur_val), 64'(0));

`ifndef DET_SEQ_AUTOINC_EN
    // Eng_done and Enter are ignored while idle
    Eng_det = 32'd5; Eng_done = 1'b1;
    tick();
    Eng_done = 1'b0;
    check("idle_done_ignored", 64'(Det), 64'(0));
    Row = 3'd2; Col = 3'd5; Data = 4'd3; Enter = 1'b1;
    tick();
    Enter = 1'b0;
    check("idle_enter_ignored", 64'(Cur_val), 64'(0));

    pulse_start();
    check("to_enter", 64'(q_Enter), 64'(1));
    write_el(3'd2, 3'd5, 4'd9);
    check("cur_idx_21", 64'(Cur_idx), 64'(21));
    check("cur_val_21", 64'(Cur_val), 64'(9));

    write_el(3'd0, 3'd0, 4'd1);
    write_el(3'd0, 3'd1, 4'd2);
    write_el(3'd1, 3'd0, 4'd3);
    // Last write coincides with Start
    Size = 4'd2;
    mdl[9] = 4'd4;
    push_stream(Size);
    Row = 3'd1; Col = 3'd1; Data = 4'd4; Enter = 1'b1; Start = 1'b1;
    tick();
    Enter = 1'b0; Start = 1'b0;
    check("to_load", 64'(q_Load), 64'(1));
    check("load_cur_idx0", 64'(Cur_idx), 64'(0));
    run_load(2, 4'b1111);
    check("eng_start_pulse", 64'(Eng_start), 64'(1));
    check("in_comp", 64'(q_Comp), 64'(1));
    pulse_start();
    check("eng_start_one_cycle", 64'(Eng_start), 64'(0));
    check("comp_start_ignored", 64'(q_Comp), 64'(1));
    Eng_det = 32'hFFFF_FFFE; Eng_done = 1'b1;
    tick();
    Eng_done = 1'b0;
    check("det_neg2", 64'(Det), 64'(32'hFFFF_FFFE));
    check("q_done", 64'(q_Done), 64'(1));
    Eng_det = 32'd3; Eng_done = 1'b1;
    tick();
    Eng_done = 1'b0;
    check("done_det_held", 64'(Det), 64'(32'hFFFF_FFFE));
    pulse_start();
    check("ack_q_I", 64'(q_I), 64'(1));
    check("ack_det_held", 64'(Det), 64'(32'hFFFF_FFFE));

    // Stall pattern 1,0,0,1 over the persisted array
    pulse_start();
    push_stream(Size);
    pulse_start();
    run_load(2, 4'b1001);
    check("stall_eng_start", 64'(Eng_start), 64'(1));
    finish_run(32'd17);

    // Size 0 streams one element
    pulse_start();
    Size = 4'd0;
    push_stream(Size);
    pulse_start();
    run_load(1, 4'b1111);
    check("size0_eng_start", 64'(Eng_start), 64'(1));
    finish_run(32'h8000_0001);

    // Size above 8 clamps to 8; Start during LOAD ignored
    pulse_start();
    for (int k = 0; k < 8; k++)
      write_el(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), ELEM_W'($urandom));
    Size = 4'd12;
    push_stream(Size);
    pulse_start();
    pulse_start();
    check("load_start_ignored", 64'(q_Load), 64'(1));
    check("load_start_ptr", 64'(Cur_idx), 64'(0));
    run_load(8, 4'b1011);
    finish_run(32'h1234_5678);

    // Reset in mid-LOAD aborts and clears the array
    pulse_start();
    Size = 4'd8;
    pulse_start();
    Ld_ready = 1'b1;
    repeat (3) tick();
    #2 Reset = 1'b1;
    #1;
    check("mid_rst_q_I", 64'(q_I), 64'(1));
    check("mid_rst_ld_valid", 64'(Ld_valid), 64'(0));
    Ld_ready = 1'b0;
    tick();
    Reset = 1'b0;
    for (int i = 0; i < 64; i++) mdl[i] = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("post_rst_quiet", 64'({Ld_valid, Eng_start}), 64'(0));
    end
    pulse_start();
    for (int i = 0; i < 64; i++) begin
      Row = 3'(i / 8); Col = 3'(i % 8);
      #1;
      check("array_cleared", 64'(Cur_val), 64'(mdl[i]));
    end
`else
    // 65 writes with the auto-increment pointer: the last lands on index 0
    pulse_start();
    Enter = 1'b1;
    for (int i = 0; i < 65; i++) begin
      Data = (i == 64) ? ELEM_W'(7) : ELEM_W'(i);
      mdl[i % 64] = Data;
      tick();
    end
    Enter = 1'b0;
    check("autoinc_ptr", 64'(Cur_idx), 64'(1));
    check("autoinc_val1", 64'(Cur_val), 64'(mdl[1]));
    Size = 4'd1;
    push_stream(Size);
    pulse_start();
    run_load(1, 4'b1111);
    finish_run(32'd42);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
